// File: rtl/rr_arbiter_8_pkg.sv
// Shared constants and state type for the 8-way round-robin arbiter.
package rr_arbiter_8_pkg;

   localparam int unsigned N_REQ = 8;
   localparam int unsigned IDX_W = 3;
   localparam int unsigned CNT_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating first-set search: returns the first set REQ bit at or after PTR,
// wrapping modulo N_REQ.
module rr_priority_pick
   import rr_arbiter_8_pkg::*;
(
   input  logic [N_REQ-1:0] REQ,
   input  logic [IDX_W-1:0] PTR,
   output logic [IDX_W-1:0] index,
   output logic             any
);

   logic [IDX_W-1:0] cand;

   // Walk PTR, PTR+1, ... with natural 3-bit wrap; keep the first hit.
   always_comb begin
      index = '0;
      any   = 1'b0;
      cand  = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand = PTR + IDX_W'(i);
         if (!any && REQ[cand]) begin
            index = cand;
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with bounded hold time. Owner keeps the grant until
// DONE, dropping its request, or HOLD_MAX cycles; one idle cycle between grants.
module rr_arbiter_8
   import rr_arbiter_8_pkg::*;
#(
   parameter int unsigned HOLD_MAX = 15
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [N_REQ-1:0] REQ,
   input  logic             DONE,
   output logic [N_REQ-1:0] GNT,
   output logic [IDX_W-1:0] SEL,
   output logic             VALID
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] ptr, ptr_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [N_REQ-1:0] gnt_nxt;
   logic [IDX_W-1:0] sel_nxt;
   logic             valid_nxt;
   logic             rel;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;

   rr_priority_pick u_pick (
      .REQ   (REQ),
      .PTR   (ptr),
      .index (pick_idx),
      .any   (pick_any)
   );

   // Next-state and registered-output decode.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      gnt_nxt   = GNT;
      sel_nxt   = SEL;
      valid_nxt = VALID;
      rel       = DONE || !REQ[SEL] || (cnt == CNT_LAST);
      case (state)
         IDLE: begin
            if (pick_any) begin
               gnt_nxt   = N_REQ'(1) << pick_idx;
               sel_nxt   = pick_idx;
               valid_nxt = 1'b1;
               cnt_nxt   = '0;
               state_nxt = BUSY;
            end else begin
               gnt_nxt   = '0;
               valid_nxt = 1'b0;
            end
         end
         BUSY: begin
            if (rel) begin
               gnt_nxt   = '0;
               valid_nxt = 1'b0;
               ptr_nxt   = SEL + 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, pointer, counter and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         ptr   <= '0;
         cnt   <= '0;
         GNT   <= '0;
         SEL   <= '0;
         VALID <= 1'b0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         cnt   <= cnt_nxt;
         GNT   <= gnt_nxt;
         SEL   <= sel_nxt;
         VALID <= valid_nxt;
      end
   end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: one instance at default HOLD_MAX (15)
// and one at HOLD_MAX=4 share the same stimulus; expected outputs for each are
// queued at drive time and compared one edge later.
module tb_rr_arbiter_8;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt_a, gnt_b;
   logic [2:0] sel_a, sel_b;
   logic       valid_a, valid_b;

   rr_arbiter_8 dut_a (
      .CLK(clk), .RST(rst), .REQ(req), .DONE(done),
      .GNT(gnt_a), .SEL(sel_a), .VALID(valid_a)
   );

   rr_arbiter_8 #(.HOLD_MAX(4)) dut_b (
      .CLK(clk), .RST(rst), .REQ(req), .DONE(done),
      .GNT(gnt_b), .SEL(sel_b), .VALID(valid_b)
   );

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic       done;
      logic [7:0] gnt;
      logic [2:0] sel;
   } vec_t;

   typedef struct {
      logic [7:0] gnt_a;
      logic [2:0] sel_a;
      logic [7:0] gnt_b;
      logic [2:0] sel_b;
      int         tag;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   exp_t cur;
   int   tests = 0;
   int   failed = 0;
   int   stepno = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input int tag, input logic [7:0] act,
                      input logic [7:0] want);
      tests++;
      if (act !== want) begin
         failed++;
         $display("FAIL %s step %0d: got %h, want %h", name, tag, act, want);
      end
   endtask

   // Compare every DUT output one time unit after each rising edge.
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         cur = sb.pop_front();
         chk("gnt_a",    cur.tag, gnt_a, cur.gnt_a);
         chk("sel_a",    cur.tag, {5'b0, sel_a}, {5'b0, cur.sel_a});
         chk("valid_a",  cur.tag, {7'b0, valid_a}, {7'b0, (cur.gnt_a != 8'h00)});
         chk("onehot_a", cur.tag, {7'b0, $onehot0(gnt_a)}, 8'h01);
         chk("gnt_b",    cur.tag, gnt_b, cur.gnt_b);
         chk("sel_b",    cur.tag, {5'b0, sel_b}, {5'b0, cur.sel_b});
         chk("valid_b",  cur.tag, {7'b0, valid_b}, {7'b0, (cur.gnt_b != 8'h00)});
         chk("onehot_b", cur.tag, {7'b0, $onehot0(gnt_b)}, 8'h01);
      end
   end

   task automatic step(input logic r, input logic [7:0] q, input logic d,
                       input logic [7:0] ga, input logic [2:0] sa,
                       input logic [7:0] gb, input logic [2:0] sbv);
      exp_t e;
      @(negedge clk);
      rst  = r;
      req  = q;
      done = d;
      e.gnt_a = ga;
      e.sel_a = sa;
      e.gnt_b = gb;
      e.sel_b = sbv;
      e.tag   = stepno;
      sb.push_back(e);
      stepno++;
   endtask

   function automatic void add(input logic r, input logic [7:0] q, input logic d,
                               input logic [7:0] g, input logic [2:0] s);
      vec_t v;
      v.rst  = r;
      v.req  = q;
      v.done = d;
      v.gnt  = g;
      v.sel  = s;
      tbl.push_back(v);
   endfunction

   initial begin
      logic [7:0] one;
      logic [2:0] ix;
      logic [7:0] ga, gb;
      rst  = 1'b1;
      req  = 8'h00;
      done = 1'b0;
      one  = 8'h01;

      // Reset held with all requests pending.
      for (int i = 0; i < 3; i++) add(1'b1, 8'hFF, 1'b0, 8'h00, 3'd0);
      // Rotation 0..7,0 with a one-cycle DONE pulse in each grant.
      for (int k = 0; k < 9; k++) begin
         ix = 3'(k % 8);
         add(1'b0, 8'hFF, 1'b0, one << ix, ix);
         add(1'b0, 8'hFF, 1'b1, 8'h00, ix);
      end
      // Wrap: owner 5 releases, PTR=6, REQ=05 -> 0 then 2.
      add(1'b0, 8'h20, 1'b0, 8'h20, 3'd5);
      add(1'b0, 8'h20, 1'b1, 8'h00, 3'd5);
      add(1'b0, 8'h05, 1'b0, 8'h01, 3'd0);
      add(1'b0, 8'h05, 1'b1, 8'h00, 3'd0);
      add(1'b0, 8'h05, 1'b0, 8'h04, 3'd2);
      add(1'b0, 8'h05, 1'b1, 8'h00, 3'd2);
      // DONE in IDLE ignored, SEL holds.
      add(1'b0, 8'h00, 1'b1, 8'h00, 3'd2);
      add(1'b0, 8'h00, 1'b0, 8'h00, 3'd2);
      // Owner 2; non-owner REQ[6] rises (no effect); owner drops -> idle -> 6.
      add(1'b0, 8'h04, 1'b0, 8'h04, 3'd2);
      add(1'b0, 8'h44, 1'b0, 8'h04, 3'd2);
      add(1'b0, 8'h40, 1'b0, 8'h00, 3'd2);
      add(1'b0, 8'h40, 1'b0, 8'h40, 3'd6);
      add(1'b0, 8'h40, 1'b1, 8'h00, 3'd6);
      // Mid-grant reset on owner 4, then REQ=11 picks 0.
      add(1'b0, 8'h10, 1'b0, 8'h10, 3'd4);
      add(1'b0, 8'h10, 1'b0, 8'h10, 3'd4);
      add(1'b1, 8'h11, 1'b0, 8'h00, 3'd0);
      add(1'b0, 8'h11, 1'b0, 8'h01, 3'd0);
      add(1'b0, 8'h11, 1'b1, 8'h00, 3'd0);

      foreach (tbl[i])
         step(tbl[i].rst, tbl[i].req, tbl[i].done,
              tbl[i].gnt, tbl[i].sel, tbl[i].gnt, tbl[i].sel);

      // Timeout: PTR=1, REQ=08 held, no DONE. dut_a holds 15, dut_b holds 4.
      for (int e = 1; e <= 17; e++) begin
         ga = (e <= 15 || e == 17) ? 8'h08 : 8'h00;
         gb = (e % 5 == 0) ? 8'h00 : 8'h08;
         step(1'b0, 8'h08, 1'b0, ga, 3'd3, gb, 3'd3);
      end
      step(1'b0, 8'h00, 1'b0, 8'h00, 3'd3, 8'h00, 3'd3);

      // DONE coinciding with dut_b's last hold cycle: single release.
      for (int e = 1; e <= 4; e++)
         step(1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 8'h08, 3'd3);
      step(1'b0, 8'h08, 1'b1, 8'h00, 3'd3, 8'h00, 3'd3);
      step(1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 8'h08, 3'd3);
      step(1'b0, 8'h08, 1'b1, 8'h00, 3'd3, 8'h00, 3'd3);

      @(negedge clk);
      req  = 8'h00;
      done = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("sb_drain", stepno, 8'(sb.size()), 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter HOLD_MAX, default 15, sets the maximum consecutive grant cycles per owner; legal range 1..15.
REQ-002 Port CLK, input, 1, sole clock; all state changes on its rising edge.
REQ-003 Port RST, input, 1, reset; synchronous and active-high.
REQ-004 Port REQ, input, 8, request per requester; bit k = requester k.
REQ-005 Port DONE, input, 1, current owner releases the resource; sampled only in BUSY.
REQ-006 Port GNT, output, 8, registered one-hot grant, or all-zero when no owner.
REQ-007 Port SEL, output, 3, registered index of the current or last owner; drives the 8:1 mux selects with S0=SEL[2], S1=SEL[1], S2=SEL[0].
REQ-008 Port VALID, output, 1, registered; 1 exactly when GNT is non-zero.

Function
REQ-009 The block SHALL implement two states: IDLE and BUSY.
REQ-010 The block SHALL hold a 3-bit priority pointer PTR and a 4-bit hold counter CNT.
REQ-011 In IDLE with REQ=0, the block SHALL remain in IDLE with GNT=0 and VALID=0, and SEL SHALL hold its value.
REQ-012 In IDLE with REQ!=0, the winner SHALL be the first set REQ bit searching PTR, PTR+1, ..., wrapping modulo 8.
REQ-013 On that IDLE edge, the block SHALL set GNT=one-hot(winner), SEL=winner, VALID=1 and CNT=0, and enter BUSY; latency from REQ to GNT is 1 cycle.
REQ-014 In BUSY, release SHALL occur at the edge where DONE=1, or REQ[SEL]=0, or CNT==HOLD_MAX-1; otherwise CNT increments.
REQ-015 On release, the block SHALL set GNT=0, VALID=0, PTR=(SEL+1) mod 8 with 3-bit wrap (7 -> 0), and enter IDLE; SEL SHALL be unchanged.
REQ-016 The block SHALL leave exactly one idle cycle (GNT=0) between consecutive grants, including re-grant to the same requester.
REQ-017 With no early release, an owner SHALL hold GNT for exactly HOLD_MAX cycles; with HOLD_MAX=1, grants SHALL last 1 cycle.
REQ-018 In BUSY, changes to non-owner REQ bits SHALL have no effect until release.
REQ-019 When DONE and the timeout occur in the same cycle, the block SHALL perform a single release with identical result.
REQ-020 DONE asserted in IDLE SHALL be ignored.
REQ-021 At most one GNT bit SHALL be set at any time.

Reset
REQ-022 RST=1 at an edge SHALL force state=IDLE, GNT=0, SEL=0, VALID=0, PTR=0 and CNT=0, overriding all other inputs, including mid-grant.
REQ-023 The first arbitration after RST deasserts SHALL occur at the next edge, with requester 0 having highest priority.

Structure
REQ-024 The requester count (8), index width (3), counter width (4) and state encodings (IDLE=0, BUSY=1) SHALL live in a shared constants include file used by the arbiter and benches.
REQ-025 The rotating first-set search SHALL be one combinational sub-module, rr_priority_pick: inputs REQ[7:0] and PTR[2:0]; outputs index[2:0] and any.
REQ-026 rr_arbiter_8 SHALL contain the FSM, counter and output registers; the datapath mux is instantiated outside this block.

Verification
REQ-027 Reset: RST=1 with REQ=8'hFF for 3 cycles -> GNT=0, VALID=0, SEL=0; RST=0 -> one edge later GNT=8'h01, SEL=0.
REQ-028 Rotation: REQ=8'hFF, DONE pulsed 1 cycle in each grant -> owners 0,1,...,7,0 in order, each separated by one GNT=0 cycle.
REQ-029 Wrap: owner 5 releases (PTR=6), REQ=8'h05 -> next GNT=8'h01 (SEL=0); after its release -> GNT=8'h04 (SEL=2).
REQ-030 Timeout: HOLD_MAX=4, REQ=8'h08, DONE=0 -> GNT=8'h08 for exactly 4 cycles, 1 idle cycle, then GNT=8'h08 again.
REQ-031 Drop and conflict: owner 2 deasserts REQ[2] while REQ[6]=1 -> GNT=0 next edge, GNT=8'h40 one edge later; in a separate run, DONE=1 coinciding with CNT=HOLD_MAX-1 -> single release.
REQ-032 Mid-grant reset: RST=1 during BUSY owner 4 -> next edge GNT=0, PTR=0; with REQ=8'h11 after release -> GNT=8'h01 (SEL=0).
